// File: rtl/common_pkg.sv
// Shared bus widths, SRAM request record and timing helpers for the SRAM peripheral.
package common_pkg;

    localparam int WB_ADDR_WIDTH  = 24;
    localparam int DATA_WIDTH     = 8;
    localparam int RAM_ADDR_WIDTH = 17;

    // System clock period used to turn datasheet nanoseconds into clock counts.
    localparam int CLK_PERIOD_NS  = 20;

    // One queued SRAM access as captured from the Wishbone request.
    typedef struct packed {
        logic [RAM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
        logic                      we;
    } sram_req_t;

    // Round a datasheet time up to whole clocks.
    function automatic int ns_to_cycles(input int ns);
        return (ns + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    endfunction

    // True when the timing set is usable and every count fits the counter.
    function automatic bit timing_params_ok(input int rd_cycles, input int wr_cycles,
                                            input int turn_cycles, input int cnt_width);
        int max_c;
        max_c = rd_cycles;
        if (wr_cycles > max_c)   max_c = wr_cycles;
        if (turn_cycles > max_c) max_c = turn_cycles;
        return (rd_cycles >= 1) && (wr_cycles >= 1) && (turn_cycles >= 0) &&
               (cnt_width >= 1) && (cnt_width < 31) && (max_c < (1 << cnt_width));
    endfunction

endpackage

// File: rtl/wb_req_buffer.sv
// One-entry request holding register: lets a new request be accepted while an access runs.
module wb_req_buffer
    import common_pkg::*;
(
    input  logic      clk,
    input  logic      srst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  sram_req_t req_i,
    output sram_req_t req_o,
    output logic      valid_o,
    output logic      stall_o
);

    sram_req_t req_q, req_d;
    logic      valid_q, valid_d;

    // Flush wins; a push on the same edge as a pop leaves the new request held.
    always_comb begin
        req_d   = req_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk) begin
        if (srst) begin
            req_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign req_o   = req_q;
    assign valid_o = valid_q;
    assign stall_o = valid_q;

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone pipelined peripheral driving an asynchronous SRAM with parametrised timing.
module sram_wb_ctrl #(
    parameter int RAM_ADDR_WIDTH = common_pkg::RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = common_pkg::DATA_WIDTH,
    parameter int READ_CYCLES    = 4,
    parameter int WRITE_CYCLES   = common_pkg::ns_to_cycles(45),
    parameter int TURN_CYCLES    = 1,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                                 wb_clock_i,
    input  logic                                 wb_reset_i,
    input  logic [common_pkg::WB_ADDR_WIDTH-1:0] wbp_addr_i,
    input  logic [DATA_WIDTH-1:0]                wbp_data_i,
    output logic [DATA_WIDTH-1:0]                wbp_data_o,
    input  logic                                 wbp_we_i,
    input  logic                                 wbp_cycle_i,
    input  logic                                 wbp_strobe_i,
    input  logic                                 wbp_sel_i,
    output logic                                 wbp_stall_o,
    output logic                                 wbp_ack_o,
    output logic                                 ram_oe_o,
    output logic                                 ram_we_o,
    output logic [RAM_ADDR_WIDTH-1:0]            ram_addr_o,
    input  logic [DATA_WIDTH-1:0]                ram_data_i,
    output logic [DATA_WIDTH-1:0]                ram_data_o,
    output logic                                 ram_data_oe,
    output logic                                 busy_o
);

    import common_pkg::sram_req_t;
    import common_pkg::timing_params_ok;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_TURN     = 3'd2;
    localparam logic [2:0] S_WSETUP   = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_WRECOVER = 3'd5;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] READ_LAST  = CNT_WIDTH'(READ_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WRITE_LAST = CNT_WIDTH'(WRITE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TURN_LAST  = CNT_WIDTH'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    // Elaboration guard: bad timing or widths that disagree with the request record.
    if (!timing_params_ok(READ_CYCLES, WRITE_CYCLES, TURN_CYCLES, CNT_WIDTH)) begin : g_bad_timing
        $error("sram_wb_ctrl: timing parameters invalid or do not fit CNT_WIDTH");
    end
    if ((RAM_ADDR_WIDTH != common_pkg::RAM_ADDR_WIDTH) ||
        (DATA_WIDTH != common_pkg::DATA_WIDTH)) begin : g_bad_width
        $error("sram_wb_ctrl: widths must match common_pkg::sram_req_t");
    end

    // Upper Wishbone address bits belong to the decoder, not the SRAM.
    if (common_pkg::WB_ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^wbp_addr_i[common_pkg::WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH];
    end

    logic [2:0]                state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      oe_q, oe_d;
    logic                      we_q, we_d;
    logic                      data_oe_q, data_oe_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      ack_q, ack_d;
    logic                      abort_q, abort_d;

    logic      push, pop, buf_valid, buf_stall, buf_avail;
    sram_req_t push_req, buf_req;

    assign push          = wbp_sel_i & wbp_cycle_i & wbp_strobe_i & ~buf_stall;
    assign push_req.addr = wbp_addr_i[RAM_ADDR_WIDTH-1:0];
    assign push_req.data = wbp_data_i;
    assign push_req.we   = wbp_we_i;
    // A dropped cycle discards the queued request, so it must not launch either.
    assign buf_avail     = buf_valid & wbp_cycle_i;

    wb_req_buffer u_req_buffer (
        .clk     (wb_clock_i),
        .srst    (wb_reset_i),
        .push    (push),
        .pop     (pop),
        .flush   (~wbp_cycle_i),
        .req_i   (push_req),
        .req_o   (buf_req),
        .valid_o (buf_valid),
        .stall_o (buf_stall)
    );

    // Access engine: launches buffered requests, sequences SRAM strobes, raises ack.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        oe_d      = oe_q;
        we_d      = we_q;
        data_oe_d = data_oe_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        abort_d   = abort_q | ~wbp_cycle_i;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                cnt_d   = '0;
                if (buf_avail) begin
                    pop    = 1'b1;
                    addr_d = buf_req.addr;
                    if (buf_req.we) begin
                        wdata_d   = buf_req.data;
                        data_oe_d = 1'b1;
                        state_d   = S_WSETUP;
                    end else begin
                        oe_d    = 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == READ_LAST) begin
                    rdata_d = ram_data_i;
                    ack_d   = ~abort_d;
                    cnt_d   = '0;
                    if (buf_avail && !buf_req.we) begin
                        // Chain the next read with OE held.
                        pop     = 1'b1;
                        addr_d  = buf_req.addr;
                        abort_d = 1'b0;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WSETUP: begin
                we_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (cnt_q == WRITE_LAST) begin
                    we_d    = 1'b0;
                    ack_d   = ~abort_d;
                    cnt_d   = '0;
                    state_d = S_WRECOVER;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WRECOVER: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                oe_d      = 1'b0;
                we_d      = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    // Engine registers; reset drops every strobe on the same edge.
    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            data_oe_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            data_oe_q <= data_oe_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            abort_q   <= abort_d;
        end
    end

    // Simulation trap for an encoding outside the six defined states.
    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_i) begin
            assert (state_q <= S_WRECOVER)
                else $fatal(1, "sram_wb_ctrl: illegal state %0d", state_q);
        end
    end

    assign wbp_data_o  = rdata_q;
    assign wbp_ack_o   = ack_q;
    assign wbp_stall_o = buf_stall;
    assign ram_oe_o    = oe_q;
    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_data_o  = wdata_q;
    assign ram_data_oe = data_oe_q;
    assign busy_o      = (state_q != S_IDLE) | buf_valid;

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Directed scoreboard bench for sram_wb_ctrl with a behavioural async SRAM.
module tb_sram_wb_ctrl;

    localparam int AW   = 17;
    localparam int DW   = 8;
    localparam int WBAW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic [WBAW-1:0] wbp_addr_i;
    logic [DW-1:0]   wbp_data_i;
    logic [DW-1:0]   wbp_data_o;
    logic            wbp_we_i, wbp_cycle_i, wbp_strobe_i, wbp_sel_i;
    logic            wbp_stall_o, wbp_ack_o;
    logic            ram_oe_o, ram_we_o, ram_data_oe, busy_o;
    logic [AW-1:0]   ram_addr_o;
    logic [DW-1:0]   ram_data_i, ram_data_o;

    sram_wb_ctrl dut (
        .wb_clock_i   (clk),
        .wb_reset_i   (rst),
        .wbp_addr_i   (wbp_addr_i),
        .wbp_data_i   (wbp_data_i),
        .wbp_data_o   (wbp_data_o),
        .wbp_we_i     (wbp_we_i),
        .wbp_cycle_i  (wbp_cycle_i),
        .wbp_strobe_i (wbp_strobe_i),
        .wbp_sel_i    (wbp_sel_i),
        .wbp_stall_o  (wbp_stall_o),
        .wbp_ack_o    (wbp_ack_o),
        .ram_oe_o     (ram_oe_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_i   (ram_data_i),
        .ram_data_o   (ram_data_o),
        .ram_data_oe  (ram_data_oe),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Index of the next posedge; read right after an edge it names that edge.
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    // Asynchronous SRAM model.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign ram_data_i = ram_oe_o ? mem[ram_addr_o] : '0;
    always @(posedge clk) if (ram_we_o) mem[ram_addr_o] <= ram_data_o;

    typedef struct {
        bit            is_read;
        logic [DW-1:0] data;
        int            ack_edge;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_n - 1);
        end
    endtask

    task automatic expect_ack(input bit rd, input logic [DW-1:0] d, input int e);
        exp_t x;
        x.is_read  = rd;
        x.data     = d;
        x.ack_edge = e;
        q.push_back(x);
    endtask

    // Advance to the negedge that follows edge e.
    task automatic at_edge(input int e);
        do @(negedge clk); while (edge_n - 1 < e);
    endtask

    // Present one request and return the edge that accepted it.
    task automatic issue(input logic [WBAW-1:0] a, input logic w, input logic [DW-1:0] d,
                         output int acc);
        logic was_stalled;
        bit   ok;
        ok  = 1'b0;
        acc = -1;
        @(negedge clk);
        wbp_cycle_i  = 1'b1;
        wbp_strobe_i = 1'b1;
        wbp_addr_i   = a;
        wbp_we_i     = w;
        wbp_data_i   = d;
        for (int i = 0; i < 64; i++) begin
            was_stalled = wbp_stall_o;
            @(posedge clk);
            if (!was_stalled) begin
                acc = edge_n;
                ok  = 1'b1;
                break;
            end
            #1;
        end
        #1 wbp_strobe_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: addr %0h not accepted within 64 clocks", a);
        end
        $display("issue %s addr=%06h data=%02h accepted at edge %0d", w ? "WR" : "RD", a, d, acc);
    endtask

    // Monitor: bus-conflict guard every clock and ack scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((ram_oe_o && ram_data_oe) || (ram_we_o && !ram_data_oe) || (ram_we_o && ram_oe_o)) begin
                errors++;
                $display("FAIL bus_conflict: oe=%0b we=%0b data_oe=%0b, required no overlap (edge %0d)",
                         ram_oe_o, ram_we_o, ram_data_oe, edge_n - 1);
            end
            if (wbp_ack_o) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: ack at edge %0d, none required", edge_n - 1);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.ack_edge != edge_n - 1) begin
                        errors++;
                        $display("FAIL ack_edge: got edge %0d, required %0d", edge_n - 1, mon_e.ack_edge);
                    end
                    if (mon_e.is_read) begin
                        checks++;
                        if (wbp_data_o !== mon_e.data) begin
                            errors++;
                            $display("FAIL read_data: got %02h, required %02h", wbp_data_o, mon_e.data);
                        end
                    end
                    $display("ack edge %0d %s data=%02h", edge_n - 1, mon_e.is_read ? "RD" : "WR", wbp_data_o);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, na, nb, nr, nw;
        rst          = 1'b1;
        wbp_addr_i   = '0;
        wbp_data_i   = '0;
        wbp_we_i     = 1'b0;
        wbp_cycle_i  = 1'b0;
        wbp_strobe_i = 1'b0;
        wbp_sel_i    = 1'b1;
        mem[17'h01234] <= 8'hA5;
        mem[17'h00011] <= 8'h3C;
        mem[17'h00020] <= 8'h77;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   wbp_ack_o,   0);
        chk("rst_stall", wbp_stall_o, 0);
        chk("rst_oe",    ram_oe_o,    0);
        chk("rst_we",    ram_we_o,    0);
        chk("rst_doe",   ram_data_oe, 0);
        chk("rst_busy",  busy_o,      0);
        chk("rst_addr",  ram_addr_o,  0);
        rst = 1'b0;
        wbp_cycle_i = 1'b1;

        // Single read: OE for 4 clocks, ack at N+5, one TURN clock.
        issue(24'h001234, 1'b0, 8'h00, n);
        expect_ack(1'b1, 8'hA5, n + 5);
        for (int k = 1; k <= 6; k++) begin
            at_edge(n + k);
            if (k <= 5) chk($sformatf("t1_oe_k%0d", k), ram_oe_o, (k <= 4) ? 1 : 0);
            if (k == 1) chk("t1_addr", ram_addr_o, 17'h01234);
            if (k == 5) chk("t1_turn_busy", busy_o, 1);
            if (k == 6) chk("t1_idle_busy", busy_o, 0);
        end

        // Single write: WSETUP, 3 clocks WE, one recovery clock.
        issue(24'h000010, 1'b1, 8'h5A, n);
        expect_ack(1'b0, 8'h00, n + 5);
        for (int k = 1; k <= 6; k++) begin
            at_edge(n + k);
            if (k == 1) begin
                chk("t2_setup_doe", ram_data_oe, 1);
                chk("t2_setup_we",  ram_we_o,    0);
                chk("t2_data",      ram_data_o,  8'h5A);
            end
            if (k >= 2 && k <= 4) chk($sformatf("t2_we_k%0d", k), ram_we_o, 1);
            if (k == 5) begin
                chk("t2_we_end",   ram_we_o,    0);
                chk("t2_recover",  ram_data_oe, 1);
            end
            if (k == 6) chk("t2_doe_off", ram_data_oe, 0);
        end
        chk("t2_mem", mem[17'h00010], 8'h5A);

        // Back-to-back reads chained with OE held.
        issue(24'h000010, 1'b0, 8'h00, na);
        issue(24'h000011, 1'b0, 8'h00, nb);
        expect_ack(1'b1, 8'h5A, na + 5);
        expect_ack(1'b1, 8'h3C, na + 9);
        chk("t3_accept_edge", nb, na + 2);
        at_edge(nb);
        chk("t3_stall", wbp_stall_o, 1);
        for (int k = 3; k <= 9; k++) begin
            at_edge(na + k);
            chk($sformatf("t3_oe_k%0d", k), ram_oe_o, (k <= 8) ? 1 : 0);
            if (k == 5) chk("t3_addr2", ram_addr_o, 17'h00011);
        end

        // Read then write: data_oe waits for OE low plus the TURN clock.
        issue(24'h000020, 1'b0, 8'h00, nr);
        issue(24'h000021, 1'b1, 8'h99, nw);
        expect_ack(1'b1, 8'h77, nr + 5);
        expect_ack(1'b0, 8'h00, nr + 11);
        chk("t4_accept_edge", nw, nr + 2);
        at_edge(nr + 5);
        chk("t4_oe_off",   ram_oe_o,    0);
        chk("t4_doe_k5",   ram_data_oe, 0);
        at_edge(nr + 6);
        chk("t4_doe_turn", ram_data_oe, 0);
        at_edge(nr + 7);
        chk("t4_doe_on",   ram_data_oe, 1);
        at_edge(nr + 13);
        chk("t4_mem", mem[17'h00021], 8'h99);
        issue(24'h000021, 1'b0, 8'h00, n);
        expect_ack(1'b1, 8'h99, n + 5);
        at_edge(n + 6);

        // Reset during WRITE count 1: strobes drop, no ack, then a normal read.
        issue(24'h000030, 1'b1, 8'hEE, n);
        at_edge(n + 3);
        chk("t5_we_before", ram_we_o, 1);
        rst = 1'b1;
        at_edge(n + 4);
        chk("t5_we",    ram_we_o,    0);
        chk("t5_doe",   ram_data_oe, 0);
        chk("t5_ack",   wbp_ack_o,   0);
        chk("t5_stall", wbp_stall_o, 0);
        chk("t5_busy",  busy_o,      0);
        rst = 1'b0;
        issue(24'h001234, 1'b0, 8'h00, n);
        expect_ack(1'b1, 8'hA5, n + 5);
        at_edge(n + 6);

        // Cycle dropped with a request buffered: discard it, finish the access silently.
        issue(24'h001234, 1'b0, 8'h00, na);
        issue(24'h000011, 1'b0, 8'h00, nb);
        wbp_cycle_i = 1'b0;
        chk("t6_accept_edge", nb, na + 2);
        at_edge(nb);
        chk("t6_stall_held", wbp_stall_o, 1);
        at_edge(nb + 1);
        chk("t6_stall_flushed", wbp_stall_o, 0);
        at_edge(na + 4);
        chk("t6_oe_runs", ram_oe_o, 1);
        at_edge(na + 5);
        chk("t6_oe_off", ram_oe_o, 0);
        chk("t6_no_ack", wbp_ack_o, 0);
        at_edge(na + 10);
        chk("t6_oe_idle", ram_oe_o, 0);
        chk("t6_addr",    ram_addr_o, 17'h01234);
        chk("t6_busy",    busy_o, 0);
        wbp_cycle_i = 1'b1;

        at_edge(edge_n + 4);
        chk("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_wb_ctrl.md
Name: sram_wb_ctrl

Overview:
Wishbone B4 pipelined peripheral giving the MCU (via SPI bridge) access to asynchronous SRAM, granted the system bus by the arbiter between video and CPU slots. It generalises the existing fixed-timing RAM peripheral with parametrised read, write and turnaround timing. It adds a one-entry request buffer so a new request can be accepted while an access is in flight. Back-to-back reads are chained with OE held, and both reset and early cycle termination are handled deterministically.

Parameters:
RAM_ADDR_WIDTH, 17, SRAM address bits taken from wbp_addr_i LSBs
DATA_WIDTH, 8, data bus width
READ_CYCLES, 4, clocks OE/address held before read data is captured (>=1)
WRITE_CYCLES, 3, clocks WE held high (>=1; set via common_pkg::ns_to_cycles(45))
TURN_CYCLES, 1, idle clocks after OE deasserts before the FPGA may drive data (>=0)
CNT_WIDTH, 4, timing counter width; must hold max(READ_CYCLES, WRITE_CYCLES, TURN_CYCLES)

Ports:
wb_clock_i  in  1  system clock
wb_reset_i  in  1  synchronous, active-high reset
wbp_addr_i  in  WB_ADDR_WIDTH  Wishbone address
wbp_data_i  in  DATA_WIDTH  write data
wbp_data_o  out  DATA_WIDTH  read data, valid while wbp_ack_o=1
wbp_we_i  in  1  1=write, 0=read
wbp_cycle_i  in  1  bus cycle active
wbp_strobe_i  in  1  request valid
wbp_sel_i  in  1  peripheral selected by address decode
wbp_stall_o  out  1  request buffer full, registered
wbp_ack_o  out  1  one-clock completion pulse per accepted request
ram_oe_o  out  1  SRAM output enable
ram_we_o  out  1  SRAM write enable
ram_addr_o  out  RAM_ADDR_WIDTH  SRAM address
ram_data_i  in  DATA_WIDTH  SRAM read data
ram_data_o  out  DATA_WIDTH  SRAM write data
ram_data_oe  out  1  FPGA data-bus tri-state enable
busy_o  out  1  engine not IDLE or buffer valid; used by the arbiter to hold the grant

Behaviour:
- Reset: all outputs 0; buffer empty; state IDLE; counter 0. Reset mid-access aborts immediately: OE, WE and data_oe drop on that edge, and no ack is issued.
- Accept: on an edge where sel&cycle&strobe&!stall, {addr, data, we} is captured into the buffer. stall_o equals buffer-valid. An accept and a buffer pop on the same edge leave the buffer valid, holding the new request.
- Early termination: if cycle_i=0 while the buffer is valid, the buffered request is discarded. If cycle_i=0 during an in-flight access, SRAM timing completes but the ack is suppressed.
- States: IDLE, READ, TURN, WSETUP, WRITE, WRECOVER.
- IDLE with buffer valid (launch edge): pop the buffer and drive ram_addr_o.
  - Read: OE<=1, go to READ.
  - Write: ram_data_o<=data, data_oe<=1, WE stays 0, go to WSETUP.
- READ: counter runs from 0. On the edge where count==READ_CYCLES-1: wbp_data_o<=ram_data_i, ack<=1.
  - If the buffer holds a read: launch it on the same edge (new address, OE stays 1, remain in READ, counter resets).
  - Otherwise: OE<=0 and go to TURN (or to IDLE if TURN_CYCLES=0).
- TURN: wait TURN_CYCLES clocks, then IDLE. A write never drives data_oe while OE is high or during TURN.
- WSETUP: one clock; then WE<=1, go to WRITE.
- WRITE: WE held WRITE_CYCLES clocks. On the final edge: WE<=0, ack<=1, go to WRECOVER.
- WRECOVER: one clock with data_oe and data still held; then data_oe<=0 and go to IDLE.
- Ack is 0 on every clock other than its single completion pulse.
- Latency: a read accepted at edge N acks after edge N+1+READ_CYCLES. A write accepted at edge N acks after edge N+2+WRITE_CYCLES.
- Illegal state: simulation-only $fatal.

Decomposition:
- common_pkg: add sram_req_t struct {addr, data, we} and a validity check for the timing parameters. It already holds WB_ADDR_WIDTH, DATA_WIDTH, RAM_ADDR_WIDTH and ns_to_cycles.
- State enum stays local to the module.
- Sub-module wb_req_buffer: one-entry holding register with push/pop/flush, valid flag and stall output.

Test Plan:
- Reset, then a read of 0x01234 with the SRAM model returning 0xA5: OE high for 4 clocks, ack at edge N+5, wbp_data_o=0xA5, OE low, then 1 TURN clock.
- Write 0x5A to 0x00010: WSETUP 1 clock with data_oe=1 and WE=0; WE high for 3 clocks; ack at N+5; data_oe drops one clock after WE; model holds 0x5A.
- Reads to 0x10 then 0x11 issued back-to-back: second accepted while the first is in flight; stall=1 while buffered; OE never drops between them; acks 4 clocks apart with correct data.
- Read followed by write: data_oe rises only after OE=0 plus TURN_CYCLES; a monitor checks that OE and data_oe are never high together.
- wb_reset_i asserted during WRITE count 1: WE and data_oe go to 0 on that edge, no ack, buffer empty; the next read works normally.
- Buffered request followed by cycle_i deasserted: buffered request discarded (no SRAM access); in-flight access finishes with no ack; stall=0 afterwards.
